fir_sample_loader: RTL and testbench
====================================

// Module: fir_sample_loader
// PURPOSE
// - Upstream feeder for the FIR filter. Accepts a block of input samples on a valid/ready stream,
//   writes them to the shared sample RAM (write port), then pulses the FIR start and waits for its done.
// - Owns the RAM write port while loading. Presents the latched block config (base address, count) to the FIR.
// PARAMETERS
// - ADDR_W  10  RAM address width. Also the width of the block count and sample index.
// - DATA_W  8   sample width
// PORTS
// - clk             in   1       rising-edge clock
// - rst_n           in   1       asynchronous active-low reset
// - cfg_go          in   1       start a block load; sampled only in IDLE
// - cfg_base        in   ADDR_W  RAM start address for the block
// - cfg_count       in   ADDR_W  samples in the block
// - abort           in   1       cancel the load in progress (LOAD state only)
// - in_valid        in   1       input sample valid
// - in_data         in   DATA_W  input sample
// - in_ready        out  1       loader can accept a sample
// - mem_addr        out  ADDR_W  RAM write address
// - mem_data        out  DATA_W  RAM write data
// - mem_we          out  1       RAM write enable
// - fir_input_addr  out  ADDR_W  latched cfg_base, held stable until the next accepted cfg_go
// - fir_sample_cnt  out  ADDR_W  latched cfg_count, same hold rule
// - fir_start       out  1       one-cycle start pulse to the FIR
// - fir_done        in   1       FIR done level (high after a run, cleared by the FIR on start)
// - busy            out  1       high in any state other than IDLE
// - block_done      out  1       one-cycle pulse when the FIR finishes this block
// - checksum        out  16      modulo-2^16 sum of the loaded samples (see CONFIGURATION)
// BEHAVIOUR
// - Reset values (async, on rst_n low, including mid-operation): state=IDLE and all outputs 0.
//   Any partial block is discarded. No fir_start is issued.
// - States and transitions:
//   - IDLE -> LOAD on cfg_go with cfg_count!=0. Latch base/count; index=0.
//     cfg_go with cfg_count==0 is ignored (stay in IDLE, no pulses).
//   - LOAD: in_ready=1. A beat is accepted when in_valid&&in_ready.
//     On acceptance, next cycle: mem_we=1, mem_addr=(base+index) mod 2^ADDR_W (wraps), mem_data=in_data; index++.
//     mem_we is otherwise 0. Throughput is one sample/cycle with no bubbles.
//   - LOAD -> KICK when the beat with index==count-1 is accepted.
//     LOAD -> IDLE on abort, which has priority over a same-cycle beat; that beat is not written.
//   - KICK: in_ready=0. fir_start=1 for exactly this one cycle. This is one cycle after the final mem_we,
//     so the last write has landed. -> WAIT.
//   - WAIT: in_ready=0. Register fir_done as done_q. On fir_done&&!done_q (rising edge) -> IDLE with
//     block_done=1 for one cycle. The rising edge ignores a stale done level left from the previous block.
//     abort is ignored in KICK and WAIT.
// - cfg_go while busy is ignored. in_valid outside LOAD is ignored (in_ready=0, nothing written).
// - Latency: last beat accepted at cycle t -> mem_we at t+1 -> fir_start at t+2.
// - fir_input_addr and fir_sample_cnt change only on an accepted cfg_go.
// CONFIGURATION
// - FIR_LOADER_CHECKSUM_EN defined: checksum clears to 0 on an accepted cfg_go.
//   Each accepted beat adds zero-extended in_data, mod 2^16. The value holds after the block completes.
// - Macro undefined: checksum tied to 16'd0 and no accumulator is built.
// TESTING
// - Reset, cfg_go base=10 count=5, in_data 1..5 back-to-back -> mem_we at RAM[10..14]=1..5;
//   fir_start 2 cycles after beat 5; block_done 1 cycle after fir_done rises.
// - base=1022 count=4, data A0..A3 -> writes at 1022,1023,0,1 (wrap); fir_input_addr=1022, fir_sample_cnt=4.
// - in_valid toggled 1/0 every cycle, count=3 -> exactly 3 writes, no duplicate addresses, in_ready low after beat 3.
// - abort in the same cycle as beat 2 of count=4 -> only beat 1 written; IDLE next cycle; no fir_start;
//   then cfg_go count=0 -> stays IDLE.
// - fir_done held high from a previous run -> no block_done until it falls and rises again.
//   rst_n low during WAIT -> all outputs 0 immediately.
// - FIR_LOADER_CHECKSUM_EN, data FF,FF,02 -> checksum=16'h0200. Without the macro -> checksum=0.

Source files
------------

// File: rtl/fir_sample_loader_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fir_sample_loader_if                                                       |
// | Config, sample stream, RAM write port and FIR control of the loader.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface fir_sample_loader_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
);
    logic              cfg_go;
    logic [ADDR_W-1:0] cfg_base;
    logic [ADDR_W-1:0] cfg_count;
    logic              abort;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              mem_we;
    logic [ADDR_W-1:0] fir_input_addr;
    logic [ADDR_W-1:0] fir_sample_cnt;
    logic              fir_start;
    logic              fir_done;
    logic              busy;
    logic              block_done;
    logic [15:0]       checksum;

    // master: the loader itself; slave: the controller, stream source, RAM and FIR around it
    modport master (
        input  cfg_go, cfg_base, cfg_count, abort, in_valid, in_data, fir_done,
        output in_ready, mem_addr, mem_data, mem_we, fir_input_addr, fir_sample_cnt,
               fir_start, busy, block_done, checksum
    );

    modport slave (
        output cfg_go, cfg_base, cfg_count, abort, in_valid, in_data, fir_done,
        input  in_ready, mem_addr, mem_data, mem_we, fir_input_addr, fir_sample_cnt,
               fir_start, busy, block_done, checksum
    );
endinterface
`default_nettype wire

// File: rtl/fir_sample_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fir_sample_loader                                                          |
// | Streams a sample block into the FIR sample RAM, then starts the FIR and    |
// | waits for its done. Optional checksum: define FIR_LOADER_CHECKSUM_EN.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fir_sample_loader #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    fir_sample_loader_if.master bus
);

    localparam logic [ADDR_W-1:0] c_one = ADDR_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_KICK = 2'd2,
        ST_WAIT = 2'd3
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] r_count;
    logic [ADDR_W-1:0] r_index;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_data;
    logic              r_mem_we;
    logic              r_fir_start;
    logic              r_done_q;
    logic              r_block_done;

    logic w_go_accept;
    logic w_beat_accept;
    logic w_last_beat;

    assign w_go_accept   = (r_state == ST_IDLE) && bus.cfg_go && (bus.cfg_count != '0);
    // abort wins over a same-cycle beat, so that beat is neither written nor summed
    assign w_beat_accept = (r_state == ST_LOAD) && bus.in_valid && !bus.abort;
    assign w_last_beat   = (r_index == (r_count - c_one));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_base       <= '0;
            r_count      <= '0;
            r_index      <= '0;
            r_mem_addr   <= '0;
            r_mem_data   <= '0;
            r_mem_we     <= 1'b0;
            r_fir_start  <= 1'b0;
            r_done_q     <= 1'b0;
            r_block_done <= 1'b0;
        end else begin
            r_mem_we     <= 1'b0;
            r_fir_start  <= 1'b0;
            r_block_done <= 1'b0;
            // sampled every cycle so a level already high on entry to WAIT is not an edge
            r_done_q     <= bus.fir_done;
            case (r_state)
                ST_IDLE: begin
                    if (w_go_accept) begin
                        r_base  <= bus.cfg_base;
                        r_count <= bus.cfg_count;
                        r_index <= '0;
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (bus.abort) begin
                        r_state <= ST_IDLE;
                    end else if (w_beat_accept) begin
                        r_mem_we   <= 1'b1;
                        r_mem_addr <= r_base + r_index;
                        r_mem_data <= bus.in_data;
                        r_index    <= r_index + c_one;
                        if (w_last_beat) begin
                            r_state <= ST_KICK;
                        end
                    end
                end
                ST_KICK: begin
                    r_fir_start <= 1'b1;
                    r_state     <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (bus.fir_done && !r_done_q) begin
                        r_block_done <= 1'b1;
                        r_state      <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef FIR_LOADER_CHECKSUM_EN
    logic [15:0] r_checksum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_checksum <= '0;
        end else if (w_go_accept) begin
            r_checksum <= '0;
        end else if (w_beat_accept) begin
            r_checksum <= r_checksum + 16'(bus.in_data);
        end
    end

    assign bus.checksum = r_checksum;
`else
    assign bus.checksum = 16'd0;
`endif

    assign bus.in_ready       = (r_state == ST_LOAD);
    assign bus.busy           = (r_state != ST_IDLE);
    assign bus.mem_addr       = r_mem_addr;
    assign bus.mem_data       = r_mem_data;
    assign bus.mem_we         = r_mem_we;
    assign bus.fir_input_addr = r_base;
    assign bus.fir_sample_cnt = r_count;
    assign bus.fir_start      = r_fir_start;
    assign bus.block_done     = r_block_done;

endmodule
`default_nettype wire

// File: tb/tb_fir_sample_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fir_sample_loader                                                       |
// | Table of sample blocks plus hand sequences; RAM writes go via a scoreboard.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_fir_sample_loader;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 8;

`ifdef FIR_LOADER_CHECKSUM_EN
    localparam bit c_ck_en = 1'b1;
`else
    localparam bit c_ck_en = 1'b0;
`endif

    typedef struct {
        logic [ADDR_W-1:0] base;
        logic [ADDR_W-1:0] count;
        bit                gap;
        logic [DATA_W-1:0] data [5];
    } vec_t;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    wr_t  exp_q [$];
    vec_t vecs [4];

    fir_sample_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    fir_sample_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Every RAM write must match the oldest outstanding expected write
    always @(negedge clk) begin
        if (rst_n && bus.mem_we) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected none at %0t",
                         bus.mem_addr, bus.mem_data, $time);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("mem_addr", int'(bus.mem_addr), int'(e.addr));
                check("mem_data", int'(bus.mem_data), int'(e.data));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_block(input vec_t v, input bit stale);
        logic [15:0] sum;
        sum = '0;
        bus.cfg_base  = v.base;
        bus.cfg_count = v.count;
        bus.cfg_go    = 1'b1;
        tick();
        bus.cfg_go = 1'b0;
        check("busy_load", int'(bus.busy), 1);
        check("in_ready_load", int'(bus.in_ready), 1);
        check("fir_input_addr", int'(bus.fir_input_addr), int'(v.base));
        check("fir_sample_cnt", int'(bus.fir_sample_cnt), int'(v.count));
        for (int i = 0; i < int'(v.count); i++) begin
            if (v.gap && i > 0) begin
                bus.in_valid = 1'b0;
                tick();
                check("in_ready_gap", int'(bus.in_ready), 1);
            end
            bus.in_valid = 1'b1;
            bus.in_data  = v.data[i];
            exp_q.push_back('{addr: ADDR_W'(int'(v.base) + i), data: v.data[i]});
            sum = sum + 16'(v.data[i]);
            tick();
        end
        bus.in_valid = 1'b0;
        check("in_ready_after_last", int'(bus.in_ready), 0);
        check("fir_start_t1", int'(bus.fir_start), 0);
        tick();
        check("fir_start_t2", int'(bus.fir_start), 1);
        tick();
        check("fir_start_t3", int'(bus.fir_start), 0);
        check("busy_wait", int'(bus.busy), 1);
        if (stale) begin
            for (int k = 0; k < 3; k++) begin
                tick();
                check("block_done_stale", int'(bus.block_done), 0);
            end
            bus.fir_done = 1'b0;
            tick();
            check("block_done_low", int'(bus.block_done), 0);
        end else begin
            tick();
        end
        bus.fir_done = 1'b1;
        tick();
        check("block_done_pulse", int'(bus.block_done), 1);
        check("busy_after_done", int'(bus.busy), 0);
        tick();
        check("block_done_end", int'(bus.block_done), 0);
        bus.fir_done = 1'b0;
        check("checksum", int'(bus.checksum), c_ck_en ? int'(sum) : 0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        vecs[0] = '{base: 10'd10,   count: 10'd5, gap: 1'b0,
                    data: '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05}};
        vecs[1] = '{base: 10'd1022, count: 10'd4, gap: 1'b0,
                    data: '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'h00}};
        vecs[2] = '{base: 10'd100,  count: 10'd3, gap: 1'b1,
                    data: '{8'hFF, 8'hFF, 8'h02, 8'h00, 8'h00}};
        vecs[3] = '{base: 10'd500,  count: 10'd1, gap: 1'b0,
                    data: '{8'h7E, 8'h00, 8'h00, 8'h00, 8'h00}};

        bus.cfg_go = 1'b0; bus.cfg_base = '0; bus.cfg_count = '0; bus.abort = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.fir_done = 1'b0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        tick();
        tick();
        check("rst_busy", int'(bus.busy), 0);
        check("rst_in_ready", int'(bus.in_ready), 0);
        check("rst_mem_we", int'(bus.mem_we), 0);
        check("rst_fir_start", int'(bus.fir_start), 0);
        check("rst_checksum", int'(bus.checksum), 0);
        rst_n = 1'b1;
        tick();

        for (int v = 0; v < 4; v++) begin
            run_block(vecs[v], 1'b0);
            if (v == 2) check("checksum_ff_ff_02", int'(bus.checksum), c_ck_en ? 32'h0200 : 0);
            tick();
        end

        // Abort alongside beat 2: only beat 1 lands, no FIR start
        bus.cfg_base = 10'd200; bus.cfg_count = 10'd4; bus.cfg_go = 1'b1;
        tick();
        bus.cfg_go = 1'b0;
        bus.in_valid = 1'b1; bus.in_data = 8'h11;
        exp_q.push_back('{addr: 10'd200, data: 8'h11});
        tick();
        bus.in_data = 8'h22; bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0; bus.in_valid = 1'b0;
        check("abort_busy", int'(bus.busy), 0);
        check("abort_in_ready", int'(bus.in_ready), 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("abort_no_start", int'(bus.fir_start), 0);
        end
        check("abort_checksum", int'(bus.checksum), c_ck_en ? 32'h11 : 0);
        bus.cfg_base = 10'd7; bus.cfg_count = 10'd0; bus.cfg_go = 1'b1;
        tick();
        bus.cfg_go = 1'b0;
        check("zero_count_busy", int'(bus.busy), 0);
        check("zero_count_addr_hold", int'(bus.fir_input_addr), 200);
        tick();

        // Stale done level from a previous run must not finish the new block
        bus.fir_done = 1'b1;
        tick();
        run_block('{base: 10'd300, count: 10'd2, gap: 1'b0,
                    data: '{8'h33, 8'h44, 8'h00, 8'h00, 8'h00}}, 1'b1);
        tick();

        // Reach WAIT, try a cfg_go while busy, then reset mid-wait
        bus.cfg_base = 10'd600; bus.cfg_count = 10'd1; bus.cfg_go = 1'b1;
        tick();
        bus.cfg_go = 1'b0;
        bus.in_valid = 1'b1; bus.in_data = 8'h5A;
        exp_q.push_back('{addr: 10'd600, data: 8'h5A});
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        bus.cfg_base = 10'd5; bus.cfg_count = 10'd3; bus.cfg_go = 1'b1;
        tick();
        bus.cfg_go = 1'b0;
        check("busy_go_ignored_addr", int'(bus.fir_input_addr), 600);
        check("busy_go_ignored_cnt", int'(bus.fir_sample_cnt), 1);
        check("busy_in_wait", int'(bus.busy), 1);
        rst_n = 1'b0;
        #1;
        check("wait_rst_busy", int'(bus.busy), 0);
        check("wait_rst_addr", int'(bus.fir_input_addr), 0);
        check("wait_rst_cnt", int'(bus.fir_sample_cnt), 0);
        check("wait_rst_mem_addr", int'(bus.mem_addr), 0);
        check("wait_rst_block_done", int'(bus.block_done), 0);
        check("wait_rst_checksum", int'(bus.checksum), 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Samples offered while idle are ignored
        bus.in_valid = 1'b1; bus.in_data = 8'hEE;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("idle_in_ready", int'(bus.in_ready), 0);
            check("idle_no_start", int'(bus.fir_start), 0);
        end
        bus.in_valid = 1'b0;
        tick();
        tick();
        check("scoreboard_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
